// File: rtl/memory_pkg.sv
// Shared definitions for the picture-memory access path: FSM states, CTRL field
// layout and the word-count decode used by both read and write sides.
package memory_pkg;

  localparam int WORD_W   = 16;
  localparam int MAX_N    = 3;

  localparam int CNT_MSB  = 2;
  localparam int CNT_LSB  = 1;
  localparam int BANK_BIT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // 2'b11 saturates to the largest legal request rather than being rejected
  function automatic logic [1:0] ctrl_to_count(input logic [1:0] cnt);
    case (cnt)
      2'b00:   return 2'd1;
      2'b01:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Holds one latched request (packed words, base address, word count) and presents
// the word/address for the current index, with the base passed straight through on load.
module word_serializer
  import memory_pkg::*;
#(
  parameter int ADDR_W = 19
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    load,
  input  logic                    advance,
  input  logic [1:0]              count,
  input  logic [ADDR_W-1:0]       base,
  input  logic [MAX_N*WORD_W-1:0] data,
  output logic [WORD_W-1:0]       word,
  output logic [ADDR_W-1:0]       addr,
  output logic                    last
);

  logic [MAX_N*WORD_W-1:0] data_q;
  logic [ADDR_W-1:0]       base_q;
  logic [1:0]              count_q;
  logic [1:0]              index_q;

  logic [1:0]              index;
  logic [MAX_N*WORD_W-1:0] src;
  logic [ADDR_W-1:0]       src_base;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
      index_q <= '0;
    end else if (load) begin
      count_q <= count;
      index_q <= 2'd1;
    end else if (advance) begin
      index_q <= index_q + 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      data_q <= data;
      base_q <= base;
    end
  end

  // On the accepting edge word 0 comes from the live inputs, afterwards from the latch
  always_comb begin
    index    = load ? 2'd0 : index_q;
    src      = load ? data : data_q;
    src_base = load ? base : base_q;
    word     = src[int'(index)*WORD_W +: WORD_W];
    addr     = src_base + ADDR_W'(index);
    last     = load ? (count == 2'd1) : (index_q == count_q - 2'd1);
  end

endmodule

// File: rtl/memory_write_access.sv
// Write side of the picture memory: serialises a 1-3 word request into the output
// RAM one word per clock and completes with a 4-phase ENABLE/HANDSHAKE exchange.
module memory_write_access
  import memory_pkg::*;
#(
  parameter int ADDR_W = 19
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic [2:0]              CTRL,
  input  logic [47:0]             ADDRESS,
  input  logic [MAX_N*WORD_W-1:0] DATA,
  output logic                    HANDSHAKE,
  output logic                    BUSY,
  output logic                    MEM_WREN,
  output logic                    MEM_BANK,
  output logic [ADDR_W-1:0]       MEM_ADDRESS,
  output logic [WORD_W-1:0]       MEM_DATA
);

  state_t              state, next_state;
  logic                load, advance, wren_d, hs_d, last;
  logic [1:0]          n_req;
  logic [WORD_W-1:0]   ser_word;
  logic [ADDR_W-1:0]   ser_addr;
  logic                unused_addr_hi;

  assign n_req          = ctrl_to_count(CTRL[CNT_MSB:CNT_LSB]);
  assign unused_addr_hi = ^ADDRESS[47:ADDR_W];

  word_serializer #(.ADDR_W(ADDR_W)) u_ser (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (load),
    .advance (advance),
    .count   (n_req),
    .base    (ADDRESS[ADDR_W-1:0]),
    .data    (DATA),
    .word    (ser_word),
    .addr    (ser_addr),
    .last    (last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ENABLE) next_state = last ? DONE : WRITE;
      WRITE:   if (!ENABLE) next_state = IDLE;
               else if (last) next_state = DONE;
      DONE:    if (!ENABLE) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Dropping ENABLE mid-WRITE aborts: no further strobes and no HANDSHAKE
  always_comb begin
    load    = 1'b0;
    advance = 1'b0;
    wren_d  = 1'b0;
    hs_d    = 1'b0;
    case (state)
      IDLE: begin
        load   = ENABLE;
        wren_d = ENABLE;
      end
      WRITE: begin
        advance = ENABLE;
        wren_d  = ENABLE;
      end
      DONE:    hs_d = ENABLE;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      HANDSHAKE   <= 1'b0;
      BUSY        <= 1'b0;
      MEM_WREN    <= 1'b0;
      MEM_BANK    <= 1'b0;
      MEM_ADDRESS <= '0;
      MEM_DATA    <= '0;
    end else begin
      HANDSHAKE <= hs_d;
      BUSY      <= (next_state != IDLE);
      MEM_WREN  <= wren_d;
      if (wren_d) begin
        MEM_ADDRESS <= ser_addr;
        MEM_DATA    <= ser_word;
      end
      if (load) MEM_BANK <= CTRL[BANK_BIT];
    end
  end

endmodule
